// File: rtl/vram_fill.sv
// Rectangle-fill engine: one command per rectangle in, one byte-masked VRAM word write per cycle out.
// Optional clipping to the visible WIDTH x HEIGHT area when VRAM_FILL_CLIP_EN is defined.
module vram_fill #(
  parameter int unsigned WIDTH          = 160,
  parameter int unsigned HEIGHT         = 120,
  parameter int unsigned WORDS_PER_LINE = 80
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_x0,
  input  logic [7:0]  cmd_x1,
  input  logic [6:0]  cmd_y0,
  input  logic [6:0]  cmd_y1,
  input  logic [5:0]  cmd_color,
  output logic        vram_we,
  output logic [13:0] vram_waddr,
  output logic [15:0] vram_wdata,
  output logic [1:0]  vram_wmask,
  output logic        done
);

  if (WORDS_PER_LINE * 2 != WIDTH || HEIGHT > 128) begin : g_bad_cfg
    $error("vram_fill: inconsistent geometry parameters");
  end

  typedef enum logic [1:0] {StIdle, StFill, StDone} state_e;

  state_e      state_q, state_d;
  logic [7:0]  x0_q, x0_d, x1_q, x1_d;
  logic [6:0]  y1_q, y1_d, row_q, row_d, word_q, word_d;
  logic [13:0] line_base_q, line_base_d;

  logic        ready_q, ready_d;
  logic        we_q, we_d;
  logic [13:0] addr_q, addr_d;
  logic [15:0] data_q, data_d;
  logic [1:0]  mask_q, mask_d;
  logic        done_q, done_d;

  logic [7:0]  acc_x1;
  logic [6:0]  acc_y1;
  logic        acc_empty;
  logic [13:0] acc_base;

  // Byte enables for a word: trim the even pixel left of x0 and the odd pixel right of x1.
  function automatic logic [1:0] edge_mask(logic [6:0] word, logic [7:0] x0, logic [7:0] x1);
    logic [1:0] m;
    m = 2'b11;
    if (word == x0[7:1] && x0[0]) m[1] = 1'b0;
    if (word == x1[7:1] && !x1[0]) m[0] = 1'b0;
    return m;
  endfunction

  always_comb begin
    acc_x1    = cmd_x1;
    acc_y1    = cmd_y1;
    acc_empty = 1'b0;
`ifdef VRAM_FILL_CLIP_EN
    if (cmd_x1 > 8'(WIDTH - 1))  acc_x1 = 8'(WIDTH - 1);
    if (cmd_y1 > 7'(HEIGHT - 1)) acc_y1 = 7'(HEIGHT - 1);
    if (cmd_x0 >= 8'(WIDTH) || cmd_y0 >= 7'(HEIGHT)) acc_empty = 1'b1;
`endif
    if (cmd_x0 > acc_x1 || cmd_y0 > acc_y1) acc_empty = 1'b1;
    // y0 * 80 as y0*64 + y0*16
    acc_base = {1'b0, cmd_y0, 6'b0} + {3'b0, cmd_y0, 4'b0};
  end

  // Output registers hold the write being presented; position registers track that write.
  always_comb begin
    state_d     = state_q;
    x0_d        = x0_q;
    x1_d        = x1_q;
    y1_d        = y1_q;
    row_d       = row_q;
    word_d      = word_q;
    line_base_d = line_base_q;
    we_d        = 1'b0;
    addr_d      = addr_q;
    data_d      = data_q;
    mask_d      = mask_q;
    done_d      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          x0_d   = cmd_x0;
          x1_d   = acc_x1;
          y1_d   = acc_y1;
          data_d = {2'b00, cmd_color, 2'b00, cmd_color};
          if (acc_empty) begin
            state_d = StDone;
            done_d  = 1'b1;
          end else begin
            state_d     = StFill;
            word_d      = cmd_x0[7:1];
            row_d       = cmd_y0;
            line_base_d = acc_base;
            we_d        = 1'b1;
            addr_d      = acc_base + 14'(cmd_x0[7:1]);
            mask_d      = edge_mask(cmd_x0[7:1], cmd_x0, acc_x1);
          end
        end
      end
      StFill: begin
        if (word_q == x1_q[7:1] && row_q == y1_q) begin
          state_d = StDone;
          done_d  = 1'b1;
        end else begin
          if (word_q == x1_q[7:1]) begin
            word_d      = x0_q[7:1];
            row_d       = row_q + 7'd1;
            line_base_d = line_base_q + 14'(WORDS_PER_LINE);
          end else begin
            word_d = word_q + 7'd1;
          end
          we_d   = 1'b1;
          addr_d = line_base_d + 14'(word_d);
          mask_d = edge_mask(word_d, x0_q, x1_q);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    ready_d = (state_d == StIdle);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= StIdle;
      x0_q        <= '0;
      x1_q        <= '0;
      y1_q        <= '0;
      row_q       <= '0;
      word_q      <= '0;
      line_base_q <= '0;
      ready_q     <= 1'b1;
      we_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      mask_q      <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      x0_q        <= x0_d;
      x1_q        <= x1_d;
      y1_q        <= y1_d;
      row_q       <= row_d;
      word_q      <= word_d;
      line_base_q <= line_base_d;
      ready_q     <= ready_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      mask_q      <= mask_d;
      done_q      <= done_d;
    end
  end

  assign cmd_ready  = ready_q;
  assign vram_we    = we_q;
  assign vram_waddr = addr_q;
  assign vram_wdata = data_q;
  assign vram_wmask = mask_q;
  assign done       = done_q;

endmodule

// File: tb/tb_vram_fill.sv
// Self-checking bench for vram_fill: directed table, reset/backpressure sequences, random commands
// checked against a pixel-coverage reference model.
module tb_vram_fill;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [7:0]  cmd_x0 = '0, cmd_x1 = '0;
  logic [6:0]  cmd_y0 = '0, cmd_y1 = '0;
  logic [5:0]  cmd_color = '0;
  logic        vram_we;
  logic [13:0] vram_waddr;
  logic [15:0] vram_wdata;
  logic [1:0]  vram_wmask;
  logic        done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  vram_fill dut (
    .clk        (clk),
    .resetn     (resetn),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_x0     (cmd_x0),
    .cmd_x1     (cmd_x1),
    .cmd_y0     (cmd_y0),
    .cmd_y1     (cmd_y1),
    .cmd_color  (cmd_color),
    .vram_we    (vram_we),
    .vram_waddr (vram_waddr),
    .vram_wdata (vram_wdata),
    .vram_wmask (vram_wmask),
    .done       (done)
  );

  typedef struct {
    logic [13:0] a;
    logic [1:0]  m;
  } wr_t;

  typedef struct {
    logic [7:0]  x0, x1;
    logic [6:0]  y0, y1;
    logic [5:0]  color;
    int          nwr;
    logic [13:0] first_a;
    logic [1:0]  first_m;
    logic [13:0] last_a;
    logic [1:0]  last_m;
    logic [15:0] data;
  } vec_t;

  wr_t  exp_q[$];
  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: every pixel inside the (optionally clipped) rectangle, grouped into words per line.
  task automatic build_model(input int x0, input int x1, input int y0, input int y1);
    int ex1, ey1;
    bit empty;
    wr_t w;
    exp_q.delete();
    ex1 = x1;
    ey1 = y1;
    empty = 1'b0;
`ifdef VRAM_FILL_CLIP_EN
    if (x0 >= 160 || y0 >= 120) empty = 1'b1;
    if (ex1 > 159) ex1 = 159;
    if (ey1 > 119) ey1 = 119;
`endif
    if (x0 > ex1 || y0 > ey1) empty = 1'b1;
    if (!empty) begin
      for (int y = y0; y <= ey1; y++) begin
        for (int wd = x0 / 2; wd <= ex1 / 2; wd++) begin
          w.a = 14'((y * 80 + wd) % 16384);
          w.m = {(2 * wd >= x0 && 2 * wd <= ex1), (2 * wd + 1 >= x0 && 2 * wd + 1 <= ex1)};
          exp_q.push_back(w);
        end
      end
    end
  endtask

  task automatic run_cmd(input logic [7:0] x0, input logic [7:0] x1, input logic [6:0] y0,
                         input logic [6:0] y1, input logic [5:0] c, input bit hold,
                         output int nw, output logic [13:0] fa, output logic [1:0] fm,
                         output logic [13:0] la, output logic [1:0] lm, output logic [15:0] fd);
    int cyc, done_cyc, ready_bad;
    logic [15:0] exp_data;
    build_model(int'(x0), int'(x1), int'(y0), int'(y1));
    exp_data = {2'b00, c, 2'b00, c};
    cmd_x0 = x0; cmd_x1 = x1; cmd_y0 = y0; cmd_y1 = y1; cmd_color = c;
    cmd_valid = 1'b1;
    cyc = 0;
    while (!cmd_ready && cyc < 20000) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!cmd_ready) check("accept_timeout", 0, 1);
    @(posedge clk); #1;
    if (!hold) cmd_valid = 1'b0;
    nw = 0; done_cyc = 0; ready_bad = 0; cyc = 1;
    fa = '0; fm = '0; la = '0; lm = '0; fd = '0;
    while (done_cyc == 0 && cyc <= 10000) begin
      if (cmd_ready) ready_bad++;
      if (vram_we) begin
        if (nw == 0) begin
          fa = vram_waddr; fm = vram_wmask; fd = vram_wdata;
        end
        la = vram_waddr; lm = vram_wmask;
        if (nw < exp_q.size())
          check("write", {vram_waddr, vram_wmask, vram_wdata}, {exp_q[nw].a, exp_q[nw].m, exp_data});
        else
          check("extra_write", {vram_waddr, vram_wmask, vram_wdata}, 32'hFFFFFFFF);
        nw++;
      end
      if (done) done_cyc = cyc;
      else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    check("write_count", nw, exp_q.size());
    check("done_cycle", done_cyc, exp_q.size() + 1);
    check("ready_low_during_cmd", ready_bad, 0);
    check("we_low_at_done", vram_we, 0);
    @(posedge clk); #1;
    check("ready_after_done", cmd_ready, 1);
    check("done_one_cycle", done, 0);
  endtask

  initial begin
    int nw;
    logic [13:0] fa, la;
    logic [1:0]  fm, lm;
    logic [15:0] fd;
    logic [7:0]  rx0, rx1;
    logic [6:0]  ry0, ry1;
    int          bad;

    vecs[0] = '{8'd0, 8'd0, 7'd0, 7'd0, 6'h3F, 1, 14'd0, 2'b10, 14'd0, 2'b10, 16'h3F3F};
    vecs[1] = '{8'd1, 8'd1, 7'd0, 7'd0, 6'h01, 1, 14'd0, 2'b01, 14'd0, 2'b01, 16'h0101};
    vecs[2] = '{8'd1, 8'd4, 7'd2, 7'd3, 6'h15, 6, 14'd160, 2'b01, 14'd242, 2'b10, 16'h1515};
    vecs[3] = '{8'd0, 8'd159, 7'd0, 7'd119, 6'h2A, 9600, 14'd0, 2'b11, 14'd9599, 2'b11, 16'h2A2A};
    vecs[4] = '{8'd200, 8'd199, 7'd0, 7'd0, 6'h0C, 0, 14'd0, 2'b00, 14'd0, 2'b00, 16'h0000};
`ifdef VRAM_FILL_CLIP_EN
    vecs[5] = '{8'd150, 8'd255, 7'd110, 7'd127, 6'h30, 50, 14'd8875, 2'b11, 14'd9599, 2'b11,
                16'h3030};
`else
    vecs[5] = '{8'd150, 8'd255, 7'd110, 7'd127, 6'h30, 954, 14'd8875, 2'b11, 14'd10287, 2'b11,
                16'h3030};
`endif

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", cmd_ready, 1);
    check("rst_we", vram_we, 0);
    check("rst_addr", vram_waddr, 0);
    check("rst_data", vram_wdata, 0);
    check("rst_mask", vram_wmask, 0);
    check("rst_done", done, 0);
    resetn = 1'b1;
    @(posedge clk); #1;

    // Directed table
    for (int i = 0; i < 6; i++) begin
      run_cmd(vecs[i].x0, vecs[i].x1, vecs[i].y0, vecs[i].y1, vecs[i].color, 1'b0,
              nw, fa, fm, la, lm, fd);
      check($sformatf("vec%0d_nwr", i), nw, vecs[i].nwr);
      if (vecs[i].nwr > 0) begin
        check($sformatf("vec%0d_first", i), {fa, fm}, {vecs[i].first_a, vecs[i].first_m});
        check($sformatf("vec%0d_last", i), {la, lm}, {vecs[i].last_a, vecs[i].last_m});
        check($sformatf("vec%0d_data", i), fd, vecs[i].data);
      end
    end

    // Reset during the third write of a full-screen fill
    cmd_x0 = 8'd0; cmd_x1 = 8'd159; cmd_y0 = 7'd0; cmd_y1 = 7'd119; cmd_color = 6'h11;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("mid_w1", {vram_we, vram_waddr}, {1'b1, 14'd0});
    @(posedge clk); #1;
    check("mid_w2", {vram_we, vram_waddr}, {1'b1, 14'd1});
    @(posedge clk); #1;
    check("mid_w3", {vram_we, vram_waddr}, {1'b1, 14'd2});
    resetn = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_we", vram_we, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_ready", cmd_ready, 1);
    resetn = 1'b1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (vram_we || done || !cmd_ready) bad++;
    end
    check("mid_rst_quiet", bad, 0);
    run_cmd(8'd3, 8'd8, 7'd5, 7'd6, 6'h2D, 1'b0, nw, fa, fm, la, lm, fd);
    check("post_rst_first", {fa, fm}, {14'd401, 2'b01});

    // cmd_valid held through the fill: the same command is taken again only once ready rises
    run_cmd(8'd1, 8'd4, 7'd2, 7'd3, 6'h15, 1'b1, nw, fa, fm, la, lm, fd);
    run_cmd(8'd1, 8'd4, 7'd2, 7'd3, 6'h15, 1'b0, nw, fa, fm, la, lm, fd);
    check("held_reaccept_nwr", nw, 6);

    // Random commands against the model
    for (int i = 0; i < 40; i++) begin
      rx0 = 8'($urandom_range(0, 255));
      rx1 = 8'(int'(rx0) + $urandom_range(0, 24) - 3);
      if (rx1 < 8'd4 && rx0 > 8'd200) rx1 = 8'd255;
      ry0 = 7'($urandom_range(0, 127));
      ry1 = 7'(int'(ry0) + $urandom_range(0, 5) - 1);
      if (ry1 < 7'd2 && ry0 > 7'd100) ry1 = 7'd127;
      run_cmd(rx0, rx1, ry0, ry1, 6'($urandom), 1'b0, nw, fa, fm, la, lm, fd);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vram_fill.md
# vram_fill

Rectangle-fill engine that writes solid-colour rectangles into the 160×120 colour VRAM scanned out by the VGA stage. It accepts one command per rectangle over a valid/ready handshake and emits one byte-masked 16-bit VRAM write per cycle. Pixel packing matches scan-out: 80 words per line, two 8-bit pixels per word, with the even pixel in bits 15:8. It sits directly upstream of the VRAM write port.

## Interface
- `WIDTH`, 160, logical pixels per line
- `HEIGHT`, 120, logical lines
- `WORDS_PER_LINE`, 80, VRAM words per line (WIDTH/2)
- `clk`  in  1  system clock
- `resetn`  in  1  synchronous, active-low reset
- `cmd_valid`  in  1  command present
- `cmd_ready`  out  1  engine idle; command accepted when `cmd_valid && cmd_ready`
- `cmd_x0`, `cmd_x1`  in  8  inclusive left/right pixel column
- `cmd_y0`, `cmd_y1`  in  7  inclusive top/bottom line
- `cmd_color`  in  6  {R[1:0],G[1:0],B[1:0]}
- `vram_we`  out  1  write strobe
- `vram_waddr`  out  14  word address
- `vram_wdata`  out  16  {2'b00,color,2'b00,color}
- `vram_wmask`  out  2  bit1 = high byte (even pixel), bit0 = low byte (odd pixel)
- `done`  out  1  one-cycle pulse when a command completes

## Operation
- FSM states: IDLE, FILL, DONE.
- IDLE:
  - `cmd_ready`=1.
  - On accept, latch all command fields and `line_base = y0*80`, computed with a shift-add (64+16), no multiplier.
  - Set `word = x0>>1` and `row = y0`, then go to FILL.
  - If `x0>x1` or `y0>y1`, go straight to DONE with no writes.
- FILL, one write per cycle:
  - `vram_waddr = line_base + word`.
  - Mask starts at 2'b11. Clear bit1 if `word == x0>>1` and x0 is odd. Clear bit0 if `word == x1>>1` and x1 is even. A single-word span applies both rules.
  - When `word == x1>>1`, end the row: set `word = x0>>1`, `row += 1`, `line_base += 80`.
  - After the last word of row y1, go to DONE.
- DONE: `done`=1 for one cycle, `vram_we`=0, return to IDLE.
- Arithmetic: `line_base` is 14 bits; sums wrap mod 2^14.
- Reset values: `cmd_ready`=1, `vram_we`=0, `vram_waddr`=0, `vram_wdata`=0, `vram_wmask`=0, `done`=0, state IDLE.
- Reset mid-FILL abandons the command. No write is issued on the cycle after the reset edge, and no `done` pulse is generated.

## Timing
- Accept at edge N. The first write is visible in the cycle after N, and write k is visible in cycle N+k.
- For R rows of W words, writes occupy cycles N+1 … N+R·W. `done` is high in cycle N+R·W+1, and `cmd_ready` returns high in cycle N+R·W+2.
- An empty command puts `done` in cycle N+1.
- `cmd_ready`=0 throughout FILL and DONE. `cmd_valid` held during this time is ignored and is not consumed.
- All outputs are registered; there is no combinational path from `cmd_*` to `vram_*`.
- The VRAM port always accepts a write and has no backpressure.

## Configuration
- `VRAM_FILL_CLIP_EN` defined, evaluated at accept:
  - x1 is clamped to WIDTH-1 and y1 to HEIGHT-1.
  - A command with `x0 ≥ WIDTH` or `y0 ≥ HEIGHT` is treated as empty: no writes, DONE follows.
- `VRAM_FILL_CLIP_EN` undefined:
  - Coordinates are used unmodified. Out-of-range rectangles write to whatever 14-bit address the arithmetic produces, wrapping mod 2^14.
  - The empty-command rule (`x0>x1` or `y0>y1`) still applies.

## Test plan
- Single pixel (0,0)-(0,0), color 6'h3F → one write: addr 0, data 16'h3F3F, mask 2'b10. `done` follows in cycle N+2.
- Single pixel (1,0)-(1,0), color 6'h01 → addr 0, data 16'h0101, mask 2'b01.
- Rectangle (1,2)-(4,3), color 6'h15 → six consecutive writes:
  - addr 160 mask 01, addr 161 mask 11, addr 162 mask 10.
  - addr 240 mask 01, addr 241 mask 11, addr 242 mask 10.
  - `done` in cycle N+7.
- Full screen (0,0)-(159,119) → 9600 writes, addresses 0…9599 in order, all with mask 11. `cmd_ready` stays low until cycle N+9602.
- Clip enabled, rectangle (150,110)-(255,127) → rows 110…119, words 75…79, 50 writes, first addr 8875, last addr 9599. Clip disabled, rectangle (200,0)-(199,0) → no writes, `done` in cycle N+1.
- Mid-fill reset:
  - `resetn` low for one cycle during the third write of the full-screen fill → `vram_we`=0 the next cycle, no `done`, `cmd_ready`=1.
  - A new command issued afterwards executes normally.
  - `cmd_valid` held high during FILL is not accepted until `cmd_ready` rises.
